// File: rtl/chef_interact_ctrl.sv
// chef_interact_ctrl
// Upstream controller for the sprite tracker. It turns the chef's position,
// facing direction and interact key into tracker read/write cycles. It also
// holds the item the chef carries and the pot state (onion count, cook timer,
// soup-ready flag). The tracker tile port is taken over only while an
// interaction is in flight. At all other times the renderer's tile index
// passes straight through.
//
// Optional feature: define POT_BURN_EN to let finished soup burn after
// BURN_CYCLES clocks of sitting in the pot. Without the macro, soup stays
// ready indefinitely and no burn counter exists.
//
// Ports
//   clk            in   1  system clock
//   Reset          in   1  asynchronous, active-high reset
//   interactKey    in   1  level, synchronous to clk; acts on its rising edge
//   chefCol        in   4  chef column 0..GRID_COLS-1
//   chefRow        in   4  chef row 0..GRID_ROWS-1
//   facing         in   2  0 up, 1 down, 2 left, 3 right
//   renderTile     in   7  renderer tile index, forwarded while idle
//   spriteIndex    in   3  tracker read data, one clk after tileIndex
//   tileIndex      out  7  tile address to tracker
//   writeEnable    out  1  tracker write strobe
//   spriteIndexIn  out  3  tracker write data
//   respawnPlate   out  1  one-cycle pulse on a served order
//   correctOrder   out  1  one-cycle pulse on a served order
//   heldSprite     out  3  carried item (sprite code)
//   potOnions      out  2  onions in the pot 0..3
//   soupReady      out  1  pot holds finished soup
//   busy           out  1  an interaction is in flight
module chef_interact_ctrl #(
  parameter int GRID_COLS   = 12,
  parameter int GRID_ROWS   = 10,
  parameter int COOK_CYCLES = 150000000,
  parameter int BURN_CYCLES = 250000000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       interactKey,
  input  logic [3:0] chefCol,
  input  logic [3:0] chefRow,
  input  logic [1:0] facing,
  input  logic [6:0] renderTile,
  input  logic [2:0] spriteIndex,
  output logic [6:0] tileIndex,
  output logic       writeEnable,
  output logic [2:0] spriteIndexIn,
  output logic       respawnPlate,
  output logic       correctOrder,
  output logic [2:0] heldSprite,
  output logic [1:0] potOnions,
  output logic       soupReady,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EVAL = 2'd2,
    WR   = 2'd3
  } state_t;

  // Sprite codes understood by the tracker
  localparam logic [2:0] SPR_NONE  = 3'd0;
  localparam logic [2:0] SPR_POT   = 3'd1;
  localparam logic [2:0] SPR_PLATE = 3'd2;
  localparam logic [2:0] SPR_SOUP  = 3'd6;
  localparam logic [2:0] SPR_ORDER = 3'd7;

  // Both timers share one width so either can be sized from the larger limit.
  localparam int CNT_MAX = (COOK_CYCLES > BURN_CYCLES) ? COOK_CYCLES : BURN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] COOK_LAST = CNT_W'(COOK_CYCLES - 1);
`ifdef POT_BURN_EN
  localparam logic [CNT_W-1:0] BURN_LAST = CNT_W'(BURN_CYCLES - 1);
`endif

  localparam logic [3:0] COL_LAST = 4'(GRID_COLS - 1);
  localparam logic [3:0] ROW_LAST = 4'(GRID_ROWS - 1);
  localparam logic [6:0] COLS_7   = 7'(GRID_COLS);

  state_t           state_q, state_d;
  logic             key_q, key_d;
  logic [6:0]       tgt_q, tgt_d;
  logic [2:0]       held_q, held_d;
  logic [1:0]       pot_q, pot_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cook_cnt_q, cook_cnt_d;
`ifdef POT_BURN_EN
  logic [CNT_W-1:0] burn_cnt_q, burn_cnt_d;
`endif
  logic             we_q, we_d;
  logic [2:0]       wdata_q, wdata_d;
  logic             order_q, order_d;

  logic [3:0]       tgt_col_s;
  logic [3:0]       tgt_row_s;
  logic             tgt_ok_s;
  logic [6:0]       tgt_tile_s;
  logic             start_s;
  logic             held_onion_s;

  // Target tile from chef position plus facing offset; flags off-grid targets.
  always_comb begin
    tgt_col_s = chefCol;
    tgt_row_s = chefRow;
    tgt_ok_s  = (chefCol <= COL_LAST) && (chefRow <= ROW_LAST);
    case (facing)
      2'd0: begin
        if (chefRow == 4'd0) tgt_ok_s  = 1'b0;
        else                 tgt_row_s = chefRow - 4'd1;
      end
      2'd1: begin
        if (chefRow >= ROW_LAST) tgt_ok_s  = 1'b0;
        else                     tgt_row_s = chefRow + 4'd1;
      end
      2'd2: begin
        if (chefCol == 4'd0) tgt_ok_s  = 1'b0;
        else                 tgt_col_s = chefCol - 4'd1;
      end
      2'd3: begin
        if (chefCol >= COL_LAST) tgt_ok_s  = 1'b0;
        else                     tgt_col_s = chefCol + 4'd1;
      end
      default: tgt_ok_s = 1'b0;
    endcase
    tgt_tile_s = (7'(tgt_row_s) * COLS_7) + 7'(tgt_col_s);
  end

  // Only a fresh key press in IDLE with an on-grid target starts an interaction.
  assign start_s      = (state_q == IDLE) && interactKey && !key_q && tgt_ok_s;
  assign held_onion_s = (held_q >= 3'd3) && (held_q <= 3'd5);

  // Next-state logic: cook/burn timers, then the interaction FSM and its rules.
  always_comb begin
    state_d    = state_q;
    key_d      = interactKey;
    tgt_d      = tgt_q;
    held_d     = held_q;
    pot_d      = pot_q;
    ready_d    = ready_q;
    cook_cnt_d = CNT_ZERO;
`ifdef POT_BURN_EN
    burn_cnt_d = CNT_ZERO;
`endif
    we_d       = 1'b0;
    wdata_d    = SPR_NONE;
    order_d    = 1'b0;

    // Cook timer runs on its own whenever a full pot is not yet finished.
    if ((pot_q == 2'd3) && !ready_q) begin
      if (cook_cnt_q == COOK_LAST) begin
        ready_d    = 1'b1;
        cook_cnt_d = CNT_ZERO;
      end else begin
        cook_cnt_d = cook_cnt_q + CNT_ONE;
      end
    end else begin
      cook_cnt_d = CNT_ZERO;
    end

`ifdef POT_BURN_EN
    // Finished soup left too long burns away and empties the pot.
    if (ready_q) begin
      if (burn_cnt_q == BURN_LAST) begin
        ready_d    = 1'b0;
        pot_d      = 2'd0;
        burn_cnt_d = CNT_ZERO;
      end else begin
        burn_cnt_d = burn_cnt_q + CNT_ONE;
      end
    end else begin
      burn_cnt_d = CNT_ZERO;
    end
`endif

    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = REQ;
          tgt_d   = tgt_tile_s;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        state_d = EVAL;
      end
      EVAL: begin
        state_d = WR;
        // Rules are evaluated in priority order against the tile just read.
        // ready_q is the value registered before this edge, so a cook that
        // completes on this very edge is only visible to the next interaction.
        if ((held_q == SPR_NONE) && (spriteIndex >= 3'd2) && (spriteIndex <= 3'd5)) begin
          held_d  = spriteIndex;
          we_d    = 1'b1;
          wdata_d = SPR_NONE;
        end else if (held_onion_s && (spriteIndex == SPR_POT) && (pot_q != 2'd3) && !ready_q) begin
          pot_d  = pot_q + 2'd1;
          held_d = SPR_NONE;
        end else if ((held_q == SPR_PLATE) && (spriteIndex == SPR_POT) && ready_q) begin
          // Overrides a burn landing on the same edge: the plate gets the soup.
          held_d  = SPR_SOUP;
          pot_d   = 2'd0;
          ready_d = 1'b0;
`ifdef POT_BURN_EN
          burn_cnt_d = CNT_ZERO;
`endif
        end else if ((held_q == SPR_SOUP) && (spriteIndex == SPR_ORDER)) begin
          held_d  = SPR_NONE;
          order_d = 1'b1;
        end else if ((held_q != SPR_NONE) && (spriteIndex == SPR_NONE)) begin
          we_d    = 1'b1;
          wdata_d = held_q;
          held_d  = SPR_NONE;
        end else begin
          held_d = held_q;
        end
      end
      WR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; Reset abandons any in-flight interaction.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      key_q      <= 1'b0;
      tgt_q      <= 7'd0;
      held_q     <= SPR_NONE;
      pot_q      <= 2'd0;
      ready_q    <= 1'b0;
      cook_cnt_q <= CNT_ZERO;
`ifdef POT_BURN_EN
      burn_cnt_q <= CNT_ZERO;
`endif
      we_q       <= 1'b0;
      wdata_q    <= SPR_NONE;
      order_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      tgt_q      <= tgt_d;
      held_q     <= held_d;
      pot_q      <= pot_d;
      ready_q    <= ready_d;
      cook_cnt_q <= cook_cnt_d;
`ifdef POT_BURN_EN
      burn_cnt_q <= burn_cnt_d;
`endif
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      order_q    <= order_d;
    end
  end

  // Tracker address mux: the renderer owns the port whenever we are idle.
  always_comb begin
    if (state_q == IDLE) tileIndex = renderTile;
    else                 tileIndex = tgt_q;
  end

  assign busy          = (state_q != IDLE);
  assign writeEnable   = we_q;
  assign spriteIndexIn = wdata_q;
  assign respawnPlate  = order_q;
  assign correctOrder  = order_q;
  assign heldSprite    = held_q;
  assign potOnions     = pot_q;
  assign soupReady     = ready_q;

endmodule

// File: tb/tb_chef_interact_ctrl.sv
`timescale 1ns/1ps
module tb_chef_interact_ctrl;
  localparam int COOK = 8;
  localparam int BURN = 16;
  localparam int COLS = 12;
  localparam int ROWS = 10;

  logic       clk = 1'b0;
  logic       Reset;
  logic       interactKey;
  logic [3:0] chefCol, chefRow;
  logic [1:0] facing;
  logic [6:0] renderTile;
  logic [2:0] spriteIndex;
  logic [6:0] tileIndex;
  logic       writeEnable;
  logic [2:0] spriteIndexIn;
  logic       respawnPlate, correctOrder;
  logic [2:0] heldSprite;
  logic [1:0] potOnions;
  logic       soupReady, busy;

  int n_chk  = 0;
  int n_pass = 0;

  chef_interact_ctrl #(
    .GRID_COLS(COLS), .GRID_ROWS(ROWS), .COOK_CYCLES(COOK), .BURN_CYCLES(BURN)
  ) dut (
    .clk(clk), .Reset(Reset), .interactKey(interactKey),
    .chefCol(chefCol), .chefRow(chefRow), .facing(facing),
    .renderTile(renderTile), .spriteIndex(spriteIndex),
    .tileIndex(tileIndex), .writeEnable(writeEnable), .spriteIndexIn(spriteIndexIn),
    .respawnPlate(respawnPlate), .correctOrder(correctOrder),
    .heldSprite(heldSprite), .potOnions(potOnions), .soupReady(soupReady), .busy(busy)
  );

  always #5 clk = ~clk;

  // Tracker model: registered read, write on the clock edge.
  logic [2:0] mem [0:127];
  int cyc = 0;
  int we_seen = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    spriteIndex <= mem[tileIndex];
    if (writeEnable) begin
      mem[tileIndex] = spriteIndexIn;
      we_seen <= we_seen + 1;
    end
  end

  // Reference model: carried item, onion count, and the cycle the pot filled.
  int m_held = 0;
  int m_pot  = 0;
  int m_c3   = -1;

  function automatic bit m_ready_at(input int c);
    int el;
    if (m_pot != 3 || m_c3 < 0) return 1'b0;
    el = c - m_c3;
`ifdef POT_BURN_EN
    return (el >= COOK) && (el < COOK + BURN);
`else
    return el >= COOK;
`endif
  endfunction

  function automatic void m_settle(input int c);
`ifdef POT_BURN_EN
    if (m_pot == 3 && m_c3 >= 0 && (c - m_c3) >= COOK + BURN) begin
      m_pot = 0;
      m_c3  = -1;
    end
`endif
  endfunction

  task automatic do_reset();
    interactKey = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    m_held = 0; m_pot = 0; m_c3 = -1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 3'd0;
  endtask

  // One full interaction with checks at every phase against the model.
  task automatic interact(input int col, input int row, input int face, input bit wiggle);
    int tc, tr, tgt, t_spr, c_eval, exp_wd;
    bit on, rdy, exp_we, exp_ord;
    tc = col; tr = row;
    case (face)
      0:       tr = row - 1;
      1:       tr = row + 1;
      2:       tc = col - 1;
      default: tc = col + 1;
    endcase
    on  = (tc >= 0) && (tc < COLS) && (tr >= 0) && (tr < ROWS);
    tgt = on ? (tr * COLS + tc) : 0;
    @(negedge clk);
    chefCol = 4'(col); chefRow = 4'(row); facing = 2'(face);
    renderTile = 7'($urandom_range(0, 127));
    interactKey = 1'b1;
    @(negedge clk);
    if (!on) begin
      n_chk++; if (busy !== 1'b0) $display("FAIL offgrid_busy: got %b want 0", busy); else n_pass++;
      n_chk++; if (tileIndex !== renderTile) $display("FAIL offgrid_tile: got %0d want %0d", tileIndex, renderTile); else n_pass++;
      interactKey = 1'b0;
      return;
    end
    n_chk++; if (busy !== 1'b1) $display("FAIL req_busy: got %b want 1", busy); else n_pass++;
    n_chk++; if (tileIndex !== 7'(tgt)) $display("FAIL req_tile: got %0d want %0d", tileIndex, tgt); else n_pass++;
    t_spr = int'(mem[tgt]);
    if (wiggle) interactKey = 1'b0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b1) $display("FAIL eval_busy: got %b want 1", busy); else n_pass++;
    if (wiggle) interactKey = 1'b1;
    c_eval = cyc;
    m_settle(c_eval);
    rdy = m_ready_at(c_eval);
    exp_we = 1'b0; exp_wd = 0; exp_ord = 1'b0;
    if (m_held == 0 && t_spr >= 2 && t_spr <= 5) begin
      m_held = t_spr; exp_we = 1'b1; exp_wd = 0;
    end else if (m_held >= 3 && m_held <= 5 && t_spr == 1 && m_pot < 3 && !rdy) begin
      m_pot = m_pot + 1; m_held = 0;
      if (m_pot == 3) m_c3 = c_eval + 1;
    end else if (m_held == 2 && t_spr == 1 && rdy) begin
      m_held = 6; m_pot = 0; m_c3 = -1;
    end else if (m_held == 6 && t_spr == 7) begin
      m_held = 0; exp_ord = 1'b1;
    end else if (m_held != 0 && t_spr == 0) begin
      exp_we = 1'b1; exp_wd = m_held; m_held = 0;
    end
    @(negedge clk);
    m_settle(cyc);
    n_chk++; if (writeEnable !== exp_we) $display("FAIL wr_we: got %b want %b", writeEnable, exp_we); else n_pass++;
    if (exp_we) begin
      n_chk++; if (spriteIndexIn !== 3'(exp_wd)) $display("FAIL wr_data: got %0d want %0d", spriteIndexIn, exp_wd); else n_pass++;
    end
    n_chk++; if (correctOrder !== exp_ord) $display("FAIL wr_order: got %b want %b", correctOrder, exp_ord); else n_pass++;
    n_chk++; if (respawnPlate !== exp_ord) $display("FAIL wr_respawn: got %b want %b", respawnPlate, exp_ord); else n_pass++;
    n_chk++; if (heldSprite !== 3'(m_held)) $display("FAIL held: got %0d want %0d", heldSprite, m_held); else n_pass++;
    n_chk++; if (potOnions !== 2'(m_pot)) $display("FAIL pot: got %0d want %0d", potOnions, m_pot); else n_pass++;
    n_chk++; if (soupReady !== m_ready_at(cyc)) $display("FAIL ready: got %b want %b", soupReady, m_ready_at(cyc)); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else n_pass++;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if ({writeEnable, correctOrder, respawnPlate} !== 3'b000) $display("FAIL idle_pulses: got %b want 000", {writeEnable, correctOrder, respawnPlate}); else n_pass++;
    n_chk++; if (tileIndex !== renderTile) $display("FAIL idle_tile: got %0d want %0d", tileIndex, renderTile); else n_pass++;
    if (exp_we) begin
      n_chk++; if (mem[tgt] !== 3'(exp_wd)) $display("FAIL tracker_mem: got %0d want %0d", mem[tgt], exp_wd); else n_pass++;
    end
    if (wiggle) begin
      @(negedge clk);
      n_chk++; if (busy !== 1'b0) $display("FAIL edge_ignored: got busy %b want 0", busy); else n_pass++;
    end
    interactKey = 1'b0;
  endtask

  task automatic test_reset();
    chefCol = 4'd0; chefRow = 4'd0; facing = 2'd0; renderTile = 7'd77;
    clear_mem();
    do_reset();
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (heldSprite !== 3'd0) $display("FAIL rst_held: got %0d want 0", heldSprite); else n_pass++;
    n_chk++; if (potOnions !== 2'd0 || soupReady !== 1'b0) $display("FAIL rst_pot: got %0d/%b want 0/0", potOnions, soupReady); else n_pass++;
    n_chk++; if ({writeEnable, respawnPlate, correctOrder} !== 3'b000) $display("FAIL rst_pulses: got %b want 000", {writeEnable, respawnPlate, correctOrder}); else n_pass++;
    n_chk++; if (spriteIndexIn !== 3'd0) $display("FAIL rst_wdata: got %0d want 0", spriteIndexIn); else n_pass++;
    n_chk++; if (tileIndex !== 7'd77) $display("FAIL rst_tile: got %0d want 77", tileIndex); else n_pass++;
  endtask

  task automatic test_pickup();
    mem[54] = 3'd3;
    interact(5, 4, 3, 1'b0);
    n_chk++; if (heldSprite !== 3'd3) $display("FAIL pickup_held: got %0d want 3", heldSprite); else n_pass++;
    n_chk++; if (mem[54] !== 3'd0) $display("FAIL pickup_tile: got %0d want 0", mem[54]); else n_pass++;
    interact(5, 4, 3, 1'b0);  // put it back on the now-empty tile
  endtask

  task automatic fill_pot();
    for (int k = 1; k <= 3; k++) begin
      mem[14] = 3'(2 + k);
      interact(2, 2, 0, 1'b0);
      interact(2, 2, 3, 1'b0);
      n_chk++; if (potOnions !== 2'(k)) $display("FAIL pot_count: got %0d want %0d", potOnions, k); else n_pass++;
    end
  endtask

  task automatic test_cook();
    int target;
    mem[27] = 3'd1; mem[25] = 3'd7;
    fill_pot();
    target = m_c3 + COOK - 1;
    for (int i = 0; i < 200 && cyc < target; i++) @(negedge clk);
    n_chk++; if (cyc !== target) $display("FAIL cook_wait: got cycle %0d want %0d", cyc, target); else n_pass++;
    n_chk++; if (soupReady !== 1'b0) $display("FAIL cook_early: got %b want 0", soupReady); else n_pass++;
    @(negedge clk);
    n_chk++; if (soupReady !== 1'b1) $display("FAIL cook_done: got %b want 1", soupReady); else n_pass++;
    mem[14] = 3'd2;
    interact(2, 2, 0, 1'b0);
    interact(2, 2, 3, 1'b0);
    n_chk++; if (heldSprite !== 3'd6 || potOnions !== 2'd0 || soupReady !== 1'b0) $display("FAIL soup: got %0d/%0d/%b want 6/0/0", heldSprite, potOnions, soupReady); else n_pass++;
  endtask

  task automatic test_order();
    interact(2, 2, 2, 1'b0);
    n_chk++; if (heldSprite !== 3'd0) $display("FAIL order_held: got %0d want 0", heldSprite); else n_pass++;
  endtask

  task automatic test_full_pot();
    fill_pot();
    mem[14] = 3'd5;
    interact(2, 2, 0, 1'b0);
    interact(2, 2, 3, 1'b0);
    n_chk++; if (heldSprite !== 3'd5 || potOnions !== 2'd3) $display("FAIL reject: got %0d/%0d want 5/3", heldSprite, potOnions); else n_pass++;
    mem[38] = 3'd0;
    interact(2, 2, 1, 1'b0);
  endtask

  task automatic test_burn();
    int target;
`ifdef POT_BURN_EN
    target = m_c3 + COOK + BURN - 1;
`else
    target = m_c3 + COOK + BURN + 4;
`endif
    for (int i = 0; i < 300 && cyc < target; i++) @(negedge clk);
    n_chk++; if (cyc !== target) $display("FAIL burn_wait: got cycle %0d want %0d", cyc, target); else n_pass++;
    n_chk++; if (soupReady !== 1'b1) $display("FAIL burn_before: got %b want 1", soupReady); else n_pass++;
    @(negedge clk);
    m_settle(cyc);
    n_chk++; if (soupReady !== m_ready_at(cyc) || potOnions !== 2'(m_pot)) $display("FAIL burn_after: got %b/%0d want %b/%0d", soupReady, potOnions, m_ready_at(cyc), m_pot); else n_pass++;
  endtask

  task automatic test_offgrid();
    interact(11, 0, 3, 1'b0);
    interact(0, 0, 0, 1'b0);
    interact(0, 5, 2, 1'b0);
    interact(3, 9, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      renderTile = 7'($urandom_range(0, 127));
      #1;
      n_chk++; if (busy !== 1'b0 || tileIndex !== renderTile) $display("FAIL offgrid_track: got %b/%0d want 0/%0d", busy, tileIndex, renderTile); else n_pass++;
    end
  endtask

  task automatic test_ignore_edge();
    mem[66] = 3'd4;
    interact(6, 6, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int we0;
    mem[66] = 3'd0;
    @(negedge clk);
    chefCol = 4'd6; chefRow = 4'd6; facing = 2'd0; interactKey = 1'b1;
    @(negedge clk);
    @(negedge clk);
    we0 = we_seen;
    Reset = 1'b1; interactKey = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || heldSprite !== 3'd0) $display("FAIL rstmid_async: got %b/%0d want 0/0", busy, heldSprite); else n_pass++;
    @(negedge clk);
    n_chk++; if (writeEnable !== 1'b0) $display("FAIL rstmid_we: got %b want 0", writeEnable); else n_pass++;
    Reset = 1'b0;
    m_held = 0; m_pot = 0; m_c3 = -1;
    repeat (2) @(negedge clk);
    n_chk++; if (we_seen !== we0 || mem[66] !== 3'd0) $display("FAIL rstmid_nowrite: got %0d writes tile %0d want 0 writes tile 0", we_seen - we0, mem[66]); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 120; i++) mem[i] = 3'($urandom_range(0, 7));
    for (int n = 0; n < 120; n++) begin
      mem[$urandom_range(0, 119)] = 3'($urandom_range(0, 7));
      interact(int'($urandom_range(0, 11)), int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    Reset = 1'b1; interactKey = 1'b0;
    test_reset();
    test_pickup();
    test_cook();
    test_order();
    test_full_pot();
    test_burn();
    test_offgrid();
    do_reset();
    test_ignore_edge();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
